// File: rtl/mux_arbiter_2ne1.sv
// Round-robin arbiter for two requesters sharing a 2:1 mux, feeding a one-entry
// valid/ready output slot that can be drained and reloaded in the same cycle.
module mux_arbiter_2ne1 #(
    parameter int WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             req0_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ready_i,
    output logic             ack0_o,
    output logic             ack1_o,
    output logic             sel_o,
    output logic [WIDTH-1:0] out_o,
    output logic             valid_o
);

    logic             valid_q, valid_d;
    logic             sel_q, sel_d;
    logic             last_sel_q, last_sel_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cap;
    logic             winner;

    // A capture may reuse the slot in the same cycle the consumer drains it.
    assign cap    = !reset_i && (req0_i || req1_i) && (!valid_q || ready_i);
    assign winner = (req0_i && req1_i) ? !last_sel_q : req1_i;

    assign ack0_o = cap && !winner;
    assign ack1_o = cap && winner;

    always_comb begin
        valid_d    = valid_q;
        sel_d      = sel_q;
        last_sel_d = last_sel_q;
        out_d      = out_q;
        if (cap) begin
            out_d      = winner ? b_i : a_i;
            sel_d      = winner;
            last_sel_d = winner;
            valid_d    = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // LastSel resets to 1 so the first tie goes to requester 0.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            valid_q    <= 1'b0;
            sel_q      <= 1'b0;
            last_sel_q <= 1'b1;
            out_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            sel_q      <= sel_d;
            last_sel_q <= last_sel_d;
            out_q      <= out_d;
        end
    end

    assign valid_o = valid_q;
    assign sel_o   = sel_q;
    assign out_o   = out_q;

endmodule
